// File: rtl/fifo_pkg.sv
// Shared defaults, pointer/count types and the one-hot decode for the FIFO controller.
package fifo_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;

  typedef logic [AW_DEF-1:0] ptr_t;
  typedef logic [AW_DEF:0]   cnt_t;

  // Occupancy view decoded from count; there is no separate state register.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  function automatic logic [DEPTH_DEF-1:0] onehot(input ptr_t p);
    logic [DEPTH_DEF-1:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Modulo-2^AW pointer register: increment enable, synchronous zero, async clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  input  logic          zero,
  output logic [AW-1:0] ptr
);
  // DEPTH is a power of two, so natural rollover gives the modulo wrap.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)     ptr <= '0;
    else if (zero) ptr <= '0;
    else if (inc)  ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for a register-file FIFO: pointers, count, flags and
// one-hot word strobes. Handshake: wr_ack is combinational with the accepted
// wr_req; rd_valid follows an accepted rd_req by exactly one cycle.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             flush,
  output logic [DEPTH-1:0] ws,
  output logic [DEPTH-1:0] rs,
  output logic [DEPTH-1:0] oe,
  output logic             mem_clr,
  output logic             wr_ack,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output fill_state_e      state
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          flush_q;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  // No pass-through: flags come from the registered count only.
  assign wr_acc = wr_req & ~full & ~flush;
  assign rd_acc = rd_req & ~empty & ~flush;
  assign wr_ack = wr_acc;
  assign ws     = wr_acc ? onehot(wr_ptr) : '0;
  assign mem_clr = clear | flush_q;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk(clk), .clear(clear), .inc(wr_acc), .zero(flush), .ptr(wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk(clk), .clear(clear), .inc(rd_acc), .zero(flush), .ptr(rd_ptr)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rs        <= '0;
      oe        <= '0;
      rd_valid  <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      flush_q <= flush;
      // Requests during a flush cycle are ignored, including for error flags.
      if (wr_req & full & ~flush)  overflow  <= 1'b1;
      if (rd_req & empty & ~flush) underflow <= 1'b1;
      if (flush) begin
        rs       <= '0;
        oe       <= '0;
        rd_valid <= 1'b0;
        count    <= '0;
      end else begin
        rs       <= rd_acc ? onehot(rd_ptr) : '0;
        oe       <= rd_acc ? onehot(rd_ptr) : '0;
        rd_valid <= rd_acc;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    state = ST_PARTIAL;
    if (empty)     state = ST_EMPTY;
    else if (full) state = ST_FULL;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencing controller for a DEPTH-word register-file FIFO built from 3-bit storage words.
- Each storage word has a read-select (RS), write-select (WS), output-enable (OE) and clear strobe; all words share one tri-state read bus.
- Block owns the read/write pointers, occupancy count and full/empty flags, and drives the per-word one-hot strobes.
- Sits between the producer/consumer request interface and the storage array; carries no data itself.

Parameters:
- DEPTH, 8, number of storage words; power of two, minimum 2.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- wr_req  in  1  producer requests a write this cycle.
- rd_req  in  1  consumer requests a read this cycle.
- flush  in  1  synchronous empty-and-wipe request.
- ws  out  DEPTH  one-hot write select to storage words.
- rs  out  DEPTH  one-hot read select to storage words.
- oe  out  DEPTH  one-hot output enable to word bus drivers.
- mem_clr  out  1  clear strobe to all storage words.
- wr_ack  out  1  write accepted this cycle.
- rd_valid  out  1  read bus carries valid data this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write requested while full.
- underflow  out  1  sticky: read requested while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is clear: asynchronous, active-high.
- Reset values while clear is high:
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - ws=0, rs=0, oe=0, rd_valid=0, overflow=0, underflow=0.
  - mem_clr=1 (combinational pass-through of clear).
- Reset mid-operation: any in-flight read is abandoned; rd_valid drops immediately.
- Accept rules:
  - wr_acc = wr_req & ~full & ~flush.
  - rd_acc = rd_req & ~empty & ~flush.
  - Full and empty are evaluated on registered count only. There is no pass-through: a write is rejected when full even if a read is accepted in the same cycle. A read is rejected when empty even if a write is accepted in the same cycle.
- Write path (zero latency):
  - ws = onehot(wr_ptr) when wr_acc, else 0. Combinational from the registered pointer.
  - The word captures at the same rising edge.
  - wr_ack = wr_acc, combinational.
  - On that edge, wr_ptr increments modulo DEPTH (DEPTH-1 wraps to 0).
- Read path (one-cycle latency):
  - On a rising edge with rd_acc, rs and oe register onehot(rd_ptr), rd_valid registers 1, and rd_ptr increments modulo DEPTH.
  - Otherwise rs, oe and rd_valid register 0.
  - Back-to-back reads give continuous rd_valid with rs/oe stepping one word per cycle.
  - rs and oe are never both non-zero on different words; at most one bit of each is set.
- Count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
  - full and empty are decoded combinationally from registered count.
- Error flags:
  - overflow sets on wr_req & full; underflow sets on rd_req & empty.
  - Both hold until clear only; flush does not reset them.
- Flush:
  - On a rising edge with flush=1: pointers and count go to 0; rs, oe and rd_valid go to 0.
  - mem_clr registers 1 for exactly one cycle after the flush edge.
  - Requests in the flush cycle are ignored: no ack, no error-flag set.
  - flush held for N cycles gives mem_clr high for N cycles, each lagging by one.
- State view (derived from count; no separate FSM register): EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on wr_acc.
  - PARTIAL→FULL on wr_acc with count==DEPTH-1 and no rd_acc.
  - FULL→PARTIAL on rd_acc.
  - PARTIAL→EMPTY on rd_acc with count==1 and no wr_acc.
  - Any state→EMPTY on flush.

Decomposition:
- Shared package fifo_pkg holds:
  - DEPTH and AW defaults.
  - A ptr_t typedef ([AW-1:0]).
  - A cnt_t typedef ([AW:0]).
  - The one-hot decode function.
- One natural sub-module, fifo_ptr: modulo-DEPTH pointer register with increment enable, synchronous zero and async clear. Instantiated twice (write and read).

Test Plan:
- Reset check: assert clear mid-stream with count=5 → count=0, empty=1, rs=oe=ws=0, rd_valid=0 within the same cycle; mem_clr=1 while clear is high.
- Fill to full: 8 consecutive wr_req → ws steps 0x01…0x80 with wr_ack each cycle, full=1 after the 8th edge. A 9th wr_req → wr_ack=0, ws=0, overflow=1 and stays 1.
- Wrap-around: write 8, read 5, write 5 → ws after wrap is 0x01…0x10, count=8. Subsequent reads give rs/oe 0x20,0x40,0x80,0x01,… with rd_valid one cycle after each rd_req.
- Simultaneous access: count=3, wr_req=rd_req=1 for 4 cycles → count stays 3, ws and rs each advance 4 words. At count=0 with both requested → write only, rd_valid=0, underflow=1. At count=8 with both requested → read only, wr_ack=0, overflow=1.
- Flush: count=6, flush plus wr_req and rd_req in one cycle → next cycle count=0, empty=1, mem_clr=1 for one cycle, no wr_ack, no rd_valid; sticky flags unchanged.
- Read latency: empty FIFO, write 1 word, read next cycle → rs=oe=0x01 and rd_valid=1 exactly one cycle after rd_req, then all 0; empty=1.
